lcd_timing_gen: RTL and testbench
=================================

# lcd_timing_gen

Parametrised successor of the team's fixed 800×480 LCD driver. It generates HS/VS/DE raster timing from compile-time porch parameters and pulls pixels from the frame-buffer read path over a valid/ready handshake. It expands RGB565 or passes RGB888, substitutes a fill colour on underflow, and offers a built-in colour-bar test pattern. It sits between the frame-buffer read FIFO and the panel pins, in the `lcd_clk` domain.

## Interface
Parameters:
- `H_SYNC` 128, `H_BP` 88, `H_ACTIVE` 800, `H_FP` 40: horizontal timing in pixel clocks.
- `V_SYNC` 2, `V_BP` 33, `V_ACTIVE` 480, `V_FP` 10: vertical timing in lines.
- `CNT_W` 11: counter width; must hold (sum of H terms) − 1 and (sum of V terms) − 1.
- `HS_POL` 0, `VS_POL` 0, `DE_POL` 1: active level of each strobe.
- `PIX_MODE` 0: input format; 0 = RGB565 in `pix_data[15:0]`, 1 = RGB888 in `pix_data[23:0]`.
- `FILL_RGB` 24'h000000: colour driven on underflow.

Ports:
- `lcd_clk` in 1: pixel clock.
- `rst` in 1: reset, synchronous, active-high.
- `pattern_en` in 1: request colour-bar mode; sampled at frame start.
- `ufl_clr` in 1: clears `ufl_sticky` and `ufl_cnt`.
- `pix_valid` in 1: upstream pixel available.
- `pix_ready` out 1: pixel consumed this cycle when high together with `pix_valid`.
- `pix_data` in 24: pixel word; format set by `PIX_MODE`.
- `lcd_hs`, `lcd_vs`, `lcd_de` out 1: panel strobes.
- `lcd_rgb` out 24: panel colour, {R8, G8, B8}.
- `pos_x` out CNT_W, `pos_y` out CNT_W: active-area coordinate of the current `lcd_rgb`.
- `frame_start` out 1: one-cycle pulse on the first output cycle of each frame.
- `ufl_sticky` out 1: an underflow occurred since the last clear.
- `ufl_cnt` out 16: saturating count of underflowed pixels.

## Operation
- Counters: `x` runs 0..H_TOT−1, where H_TOT = H_SYNC+H_BP+H_ACTIVE+H_FP. `y` increments when `x` wraps and runs 0..V_TOT−1.
- Sync windows: HS is active while x < H_SYNC. VS is active while y < V_SYNC.
- Active window: H_SYNC+H_BP ≤ x < H_SYNC+H_BP+H_ACTIVE, and the same form applies in y. `act` denotes this window.
- Mode latch: `pattern_en` is sampled into `pat_mode` only at x=0, y=0. It therefore never changes mid-frame.
- Normal mode, handshake:
  - `pix_ready` = `act` && !`pat_mode`, driven combinationally from the counters and independent of `pix_valid`.
  - One pixel is consumed per handshake.
  - If `act` is high and `pix_valid` is low, the pixel is an underflow. It outputs `FILL_RGB`; no pixel is skipped or later re-aligned.
- RGB565 expansion uses MSB replication: R8 = {R5, R5[4:2]}, G8 = {G6, G6[5:4]}, B8 = {B5, B5[4:2]}. So 16'hFFFF → 24'hFFFFFF.
- Pattern mode:
  - `pix_ready` = 0.
  - Eight vertical bars, each H_ACTIVE/8 wide, in order: white, yellow, cyan, green, magenta, red, blue, black. Fully saturated 8'hFF/8'h00 components.
  - Leftover columns (H_ACTIVE mod 8) are black.
- Outside `act`: `lcd_rgb` = 0, `pos_x` = `pos_y` = 0.
- Underflow accounting:
  - `ufl_sticky` sets on each underflow; `ufl_cnt` increments and saturates at 16'hFFFF.
  - `ufl_clr` clears both; clear wins over a same-cycle underflow.

## Timing
- Reset values (registered, one cycle after `rst` is sampled high):
  - Counters 0, `pat_mode` 0.
  - `lcd_hs`/`lcd_vs` at their inactive levels (~HS_POL, ~VS_POL), `lcd_de` at ~DE_POL.
  - `lcd_rgb` 0, `pos_x`/`pos_y` 0, `frame_start` 0, `ufl_sticky` 0, `ufl_cnt` 0.
  - `pix_ready` 0 while `rst` is high.
- Output latency: all panel outputs, `pos_*` and `frame_start` are registered exactly one stage after the counter state. HS, VS, DE and RGB are therefore mutually aligned.
- Handshake timing: data consumed at counter cycle n appears on `lcd_rgb` at cycle n+1.
- First output after reset: the counters start at x=0, y=0 in the first cycle after `rst` falls.
  - That cycle's outputs appear one cycle later: `frame_start` = 1 with HS and VS both active.
  - The same pulse repeats every H_TOT×V_TOT cycles.
- `rst` asserted mid-line: all state returns to reset values on the next edge; no partial line or frame completes.
- Wrap: from x = H_TOT−1, y = V_TOT−1, both counters go to 0 on the same edge.

## Structure
- Package `lcd_timing_pkg`:
  - Default timing constants for the 800×480 panel.
  - `PIX_MODE` encodings.
  - The eight bar colour constants.
  - A function `rgb565_to_888`.
- Sub-module `lcd_sync_counter`:
  - Parameterised x/y raster counter.
  - Outputs `x`, `y`, `hs_raw`, `vs_raw`, `act`, `sof`.
  - Reused by future overlay blocks.
- Top module holds the mode latch, the pixel mux, the output register stage and the underflow logic.

## Test plan
- Small-raster timing (1/1/8/1 horizontal, 1/1/4/1 vertical): after reset, `frame_start` period is 11×7 = 77 cycles. `lcd_de` is high for 8 consecutive cycles per line on 4 lines. HS and VS are low for exactly 1 cycle/line at POL = 0.
- `PIX_MODE`=0 with `pix_valid` held high and data 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF: `lcd_rgb` = FF0000, 00FF00, 0000FF, FFFFFF, one cycle after each `pix_ready` handshake.
- Underflow: drop `pix_valid` for 3 active cycles with `FILL_RGB` = 24'h123456. Expected: 3 output pixels equal 123456, `ufl_cnt` = 3, `ufl_sticky` = 1. Then pulse `ufl_clr` in the same cycle as another underflow: both counters read 0.
- Pattern mode: assert `pattern_en` mid-frame. No change until the next `frame_start`. After it, `pix_ready` stays 0 and, with H_ACTIVE = 16, pixels 0–1 are FFFFFF, 2–3 FFFF00, … and 14–15 000000.
- Reset mid-line at x = 50: the next cycle shows reset values on every output. Counting restarts at 0, and the first `frame_start` arrives 1 cycle after `rst` falls.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
// Shared definitions for the LCD raster timing generator and the blocks
// that reuse its counter:
//   - default porch/active timing for the 800x480 panel
//   - pixel input format encodings (PIX_MODE)
//   - colour-bar test pattern colours and a lookup helper
//   - RGB565 -> RGB888 expansion helper
package lcd_timing_pkg;

  // Default 800x480 panel timing, in pixel clocks / lines
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_CNT_W    = 11;

  // Pixel input formats
  localparam int PIX_MODE_RGB565 = 0;
  localparam int PIX_MODE_RGB888 = 1;

  // Colour bars, left to right, {R8, G8, B8}
  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Bar index 0..7 to colour
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  // MSB replication so full-scale 5/6-bit values map to full-scale 8-bit
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// lcd_sync_counter
// Parameterised x/y raster counter with raw (unregistered, active-high)
// timing windows derived from the current count.
// Ports:
//   clk     in  pixel clock
//   rst     in  synchronous active-high reset, counters to 0
//   x, y    out current horizontal / vertical position
//   hs_raw  out x inside the horizontal sync window
//   vs_raw  out y inside the vertical sync window
//   act     out (x, y) inside the active area
//   sof     out first cycle of the frame (x = 0, y = 0)
module lcd_sync_counter #(
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             act,
  output logic             sof
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  // Raster position: x wraps every line, y advances on the x wrap and
  // both wrap together at the last pixel of the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (x == H_LAST) begin
      x <= '0;
      if (y == V_LAST) begin
        y <= '0;
      end else begin
        y <= y + 1'b1;
      end
    end else begin
      x <= x + 1'b1;
    end
  end

  // Timing windows decoded straight from the current position
  always_comb begin
    hs_raw = (x < H_SYNC_C);
    vs_raw = (y < V_SYNC_C);
    act    = (x >= H_START) && (x < H_END) && (y >= V_START) && (y < V_END);
    sof    = (x == '0) && (y == '0);
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
// Panel timing generator: raster timing from porch parameters, pixel fetch
// over valid/ready, RGB565 expansion, underflow fill/accounting and a
// colour-bar test pattern. All panel outputs are one register stage after
// the raster counter so HS/VS/DE/RGB stay mutually aligned.
// Ports:
//   lcd_clk      in  pixel clock
//   rst          in  synchronous active-high reset
//   pattern_en   in  colour-bar request, sampled at frame start
//   ufl_clr      in  clears ufl_sticky and ufl_cnt
//   pix_valid    in  upstream pixel available
//   pix_ready    out pixel consumed when high together with pix_valid
//   pix_data     in  pixel word (RGB565 in [15:0] or RGB888)
//   lcd_hs/vs/de out panel strobes at their configured polarity
//   lcd_rgb      out panel colour {R8, G8, B8}
//   pos_x, pos_y out active-area coordinate of the current lcd_rgb
//   frame_start  out one-cycle pulse on the first output cycle of a frame
//   ufl_sticky   out underflow seen since last clear
//   ufl_cnt      out saturating underflow pixel count
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int          H_SYNC   = DEF_H_SYNC,
  parameter int          H_BP     = DEF_H_BP,
  parameter int          H_ACTIVE = DEF_H_ACTIVE,
  parameter int          H_FP     = DEF_H_FP,
  parameter int          V_SYNC   = DEF_V_SYNC,
  parameter int          V_BP     = DEF_V_BP,
  parameter int          V_ACTIVE = DEF_V_ACTIVE,
  parameter int          V_FP     = DEF_V_FP,
  parameter int          CNT_W    = DEF_CNT_W,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter logic        DE_POL   = 1'b1,
  parameter int          PIX_MODE = PIX_MODE_RGB565,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic             lcd_clk,
  input  logic             rst,
  input  logic             pattern_en,
  input  logic             ufl_clr,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [23:0]      pix_data,
  output logic             lcd_hs,
  output logic             lcd_vs,
  output logic             lcd_de,
  output logic [23:0]      lcd_rgb,
  output logic [CNT_W-1:0] pos_x,
  output logic [CNT_W-1:0] pos_y,
  output logic             frame_start,
  output logic             ufl_sticky,
  output logic [15:0]      ufl_cnt
);

  // Bars are H_ACTIVE/8 wide; any remainder columns on the right are black.
  // A raster narrower than 8 columns has no bars at all.
  localparam int BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam int BAR_END = (H_ACTIVE >= 8) ? (BAR_W * 8) : 0;

  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] BAR_W_C   = CNT_W'(BAR_W);
  localparam logic [CNT_W-1:0] BAR_END_C = CNT_W'(BAR_END);

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             hs_raw;
  logic             vs_raw;
  logic             act;
  logic             sof;
  logic             pat_mode;
  logic             ufl;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [2:0]       bar_idx;
  logic [23:0]      pix_next;

  lcd_sync_counter #(
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .CNT_W    (CNT_W)
  ) u_sync_counter (
    .clk    (lcd_clk),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw),
    .act    (act),
    .sof    (sof)
  );

  // Handshake and pixel selection for the current counter cycle.
  // pix_ready never looks at pix_valid; an active cycle without valid data
  // is an underflow and shows the fill colour without stalling the raster.
  always_comb begin
    pix_ready = act && !pat_mode && !rst;
    ufl       = act && !pat_mode && !pix_valid;
    col       = x - H_START_C;
    row       = y - V_START_C;
    bar_idx   = 3'(col / BAR_W_C);
    pix_next  = '0;
    if (act) begin
      if (pat_mode) begin
        if (col < BAR_END_C) begin
          pix_next = bar_color(bar_idx);
        end else begin
          pix_next = BAR_BLACK;
        end
      end else if (pix_valid) begin
        pix_next = (PIX_MODE == PIX_MODE_RGB888) ? pix_data : rgb565_to_888(pix_data[15:0]);
      end else begin
        pix_next = FILL_RGB;
      end
    end
  end

  // Output stage, one cycle behind the counter. The mode latch updates only
  // at the end of the first cycle of a frame, so a frame never mixes modes.
  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      lcd_hs      <= ~HS_POL;
      lcd_vs      <= ~VS_POL;
      lcd_de      <= ~DE_POL;
      lcd_rgb     <= '0;
      pos_x       <= '0;
      pos_y       <= '0;
      frame_start <= 1'b0;
      pat_mode    <= 1'b0;
    end else begin
      lcd_hs      <= hs_raw ? HS_POL : ~HS_POL;
      lcd_vs      <= vs_raw ? VS_POL : ~VS_POL;
      lcd_de      <= act ? DE_POL : ~DE_POL;
      lcd_rgb     <= pix_next;
      pos_x       <= act ? col : '0;
      pos_y       <= act ? row : '0;
      frame_start <= sof;
      if (sof) begin
        pat_mode <= pattern_en;
      end
    end
  end

  // Underflow accounting; a clear takes priority over an underflow that
  // happens in the same cycle
  always_ff @(posedge lcd_clk) begin
    if (rst || ufl_clr) begin
      ufl_sticky <= 1'b0;
      ufl_cnt    <= '0;
    end else if (ufl) begin
      ufl_sticky <= 1'b1;
      if (ufl_cnt != 16'hFFFF) begin
        ufl_cnt <= ufl_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen
// Self-checking bench for lcd_timing_gen on two small rasters:
//   dut     : 1/1/8/1 x 1/1/4/1, RGB565, fill 24'h123456 (timing, data,
//             underflow, mid-line reset) against a cycle model + scoreboard
//   dut_pat : 1/1/18/1 x 1/1/4/1 for the colour-bar pattern, including
//             the two leftover black columns
module tb_lcd_timing_gen;

  localparam int HT = 11;
  localparam int VT = 7;
  localparam int NV = 7;
  localparam logic [23:0] FILL = 24'h123456;

  typedef struct packed {
    logic [15:0] data;
    logic [23:0] rgb;
  } vec_t;

  logic        lcd_clk = 1'b0;
  logic        rst = 1'b1;
  logic        pattern_en = 1'b0;
  logic        ufl_clr = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_ready;
  logic        lcd_hs, lcd_vs, lcd_de, frame_start, ufl_sticky;
  logic [23:0] lcd_rgb;
  logic [10:0] pos_x, pos_y;
  logic [15:0] ufl_cnt;

  logic        p_en = 1'b0;
  logic        p_ready, p_hs, p_vs, p_de, p_fs, p_sticky;
  logic [23:0] p_rgb;
  logic [10:0] p_px, p_py;
  logic [15:0] p_ufl_cnt;

  always #5 lcd_clk = ~lcd_clk;

  lcd_timing_gen #(
    .H_SYNC(1), .H_BP(1), .H_ACTIVE(8), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .CNT_W(11), .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b1),
    .PIX_MODE(0), .FILL_RGB(24'h123456)
  ) dut (
    .lcd_clk(lcd_clk), .rst(rst), .pattern_en(pattern_en), .ufl_clr(ufl_clr),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .lcd_hs(lcd_hs), .lcd_vs(lcd_vs), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .pos_x(pos_x), .pos_y(pos_y), .frame_start(frame_start),
    .ufl_sticky(ufl_sticky), .ufl_cnt(ufl_cnt)
  );

  lcd_timing_gen #(
    .H_SYNC(1), .H_BP(1), .H_ACTIVE(18), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
    .CNT_W(11), .HS_POL(1'b0), .VS_POL(1'b0), .DE_POL(1'b1),
    .PIX_MODE(0), .FILL_RGB(24'h000000)
  ) dut_pat (
    .lcd_clk(lcd_clk), .rst(rst), .pattern_en(p_en), .ufl_clr(1'b0),
    .pix_valid(1'b1), .pix_ready(p_ready), .pix_data(24'h00001F),
    .lcd_hs(p_hs), .lcd_vs(p_vs), .lcd_de(p_de), .lcd_rgb(p_rgb),
    .pos_x(p_px), .pos_y(p_py), .frame_start(p_fs),
    .ufl_sticky(p_sticky), .ufl_cnt(p_ufl_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs[NV];
  int vi = 0;
  int mx = 0, my = 0;
  logic e_hs, e_vs, e_de, e_fs, e_sticky;
  int e_px, e_py, e_cnt;
  logic [23:0] sbq[$];
  int cyc = 0;
  int last_fs = -1;
  int de_run = 0;

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive one counter cycle of inputs into dut and advance the model
  task automatic applyStimulus(input logic r, input logic v, input logic clr);
    logic act_m;
    rst = r;
    pix_valid = v;
    pix_data = {8'h00, vecs[vi].data};
    ufl_clr = clr;
    act_m = !r && (mx >= 2) && (mx < 10) && (my >= 2) && (my < 6);
    #1;
    checkValue("pix_ready", 32'(pix_ready), 32'(act_m));
    if (r) begin
      e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
      e_px = 0; e_py = 0; e_sticky = 1'b0; e_cnt = 0;
      mx = 0; my = 0; last_fs = -1; de_run = 0;
    end else begin
      e_hs = (mx >= 1);
      e_vs = (my >= 1);
      e_de = act_m;
      e_fs = (mx == 0) && (my == 0);
      e_px = act_m ? mx - 2 : 0;
      e_py = act_m ? my - 2 : 0;
      if (act_m) begin
        sbq.push_back(v ? vecs[vi].rgb : FILL);
        if (v) vi = (vi + 1) % NV;
      end
      if (clr) begin
        e_sticky = 1'b0; e_cnt = 0;
      end else if (act_m && !v) begin
        e_sticky = 1'b1;
        if (e_cnt < 65535) e_cnt++;
      end
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) my = 0;
      end
    end
  endtask

  // Compare registered outputs of dut against the model
  task automatic checkOutput();
    logic [23:0] exp_rgb;
    cyc++;
    exp_rgb = '0;
    if (e_de) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL scoreboard: got de=1, expected a queued pixel");
      end else begin
        exp_rgb = sbq.pop_front();
      end
    end
    checkValue("lcd_hs", 32'(lcd_hs), 32'(e_hs));
    checkValue("lcd_vs", 32'(lcd_vs), 32'(e_vs));
    checkValue("lcd_de", 32'(lcd_de), 32'(e_de));
    checkValue("frame_start", 32'(frame_start), 32'(e_fs));
    checkValue("lcd_rgb", 32'(lcd_rgb), 32'(exp_rgb));
    checkValue("pos_x", 32'(pos_x), 32'(e_px));
    checkValue("pos_y", 32'(pos_y), 32'(e_py));
    checkValue("ufl_sticky", 32'(ufl_sticky), 32'(e_sticky));
    checkValue("ufl_cnt", 32'(ufl_cnt), 32'(e_cnt));
    if (lcd_de) begin
      de_run++;
    end else begin
      if (de_run != 0) checkValue("de_run_len", 32'(de_run), 32'd8);
      de_run = 0;
    end
    if (frame_start) begin
      if (last_fs >= 0) checkValue("fs_period", 32'(cyc - last_fs), 32'd77);
      last_fs = cyc;
    end
  endtask

  task automatic runCycle(input logic r, input logic v, input logic clr);
    applyStimulus(r, v, clr);
    @(posedge lcd_clk);
    #1;
    checkOutput();
  endtask

  task automatic rawTick();
    @(posedge lcd_clk);
    #1;
  endtask

  initial begin
    logic [23:0] bars[9];
    int k;
    int bad;

    vecs[0] = '{16'hF800, 24'hFF0000};
    vecs[1] = '{16'h07E0, 24'h00FF00};
    vecs[2] = '{16'h001F, 24'h0000FF};
    vecs[3] = '{16'hFFFF, 24'hFFFFFF};
    vecs[4] = '{16'h0841, 24'h080808};
    vecs[5] = '{16'h8410, 24'h848284};
    vecs[6] = '{16'h7BEF, 24'h7B7D7B};
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};

    // Reset state
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b1, 1'b0);
    checkValue("rst_hs", 32'(lcd_hs), 32'd1);
    checkValue("rst_vs", 32'(lcd_vs), 32'd1);
    checkValue("rst_de", 32'(lcd_de), 32'd0);
    checkValue("rst_rgb", 32'(lcd_rgb), 32'd0);
    checkValue("rst_fs", 32'(frame_start), 32'd0);

    // Two frames of streamed RGB565 data
    runCycle(1'b0, 1'b1, 1'b0);
    checkValue("first_fs", 32'(frame_start), 32'd1);
    for (int c = 1; c < 2 * HT * VT; c++) runCycle(1'b0, 1'b1, 1'b0);

    // Three underflows at the start of an active line
    for (k = 0; k < 200 && !(mx == 2 && my == 2); k++) runCycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) runCycle(1'b0, 1'b0, 1'b0);
    checkValue("ufl_cnt_after3", 32'(ufl_cnt), 32'd3);
    checkValue("ufl_sticky_after3", 32'(ufl_sticky), 32'd1);
    runCycle(1'b0, 1'b0, 1'b1);
    checkValue("ufl_cnt_clr_wins", 32'(ufl_cnt), 32'd0);
    checkValue("ufl_sticky_clr_wins", 32'(ufl_sticky), 32'd0);
    for (int i = 0; i < 10; i++) runCycle(1'b0, 1'b1, 1'b0);

    // Reset mid-line, then restart
    for (k = 0; k < 200 && mx != 5; k++) runCycle(1'b0, 1'b1, 1'b0);
    runCycle(1'b1, 1'b1, 1'b0);
    checkValue("midrst_hs", 32'(lcd_hs), 32'd1);
    checkValue("midrst_de", 32'(lcd_de), 32'd0);
    checkValue("midrst_rgb", 32'(lcd_rgb), 32'd0);
    checkValue("midrst_pos_x", 32'(pos_x), 32'd0);
    runCycle(1'b0, 1'b1, 1'b0);
    checkValue("midrst_first_fs", 32'(frame_start), 32'd1);
    for (int c = 0; c < HT * VT + 3; c++) runCycle(1'b0, 1'b1, 1'b0);

    // Colour-bar pattern on the second instance
    rst = 1'b1;
    p_en = 1'b0;
    rawTick();
    rst = 1'b0;
    k = 0;
    while (!p_de && k < 300) begin rawTick(); k++; end
    checkValue("pat_wait_de", 32'(p_de), 32'd1);
    checkValue("pat_pre_rgb", 32'(p_rgb), 32'h0000FF);
    checkValue("pat_pre_ready", 32'(p_ready), 32'd1);
    p_en = 1'b1;
    bad = 0;
    k = 0;
    while (!p_fs && k < 300) begin
      if (p_de && p_rgb != 24'h0000FF) bad++;
      rawTick();
      k++;
    end
    checkValue("pat_wait_fs", 32'(p_fs), 32'd1);
    checkValue("pat_no_midframe_change", 32'(bad), 32'd0);
    bad = 0;
    k = 0;
    while (!p_de && k < 100) begin
      if (p_ready) bad++;
      rawTick();
      k++;
    end
    checkValue("pat_wait_de2", 32'(p_de), 32'd1);
    for (int i = 0; i < 18; i++) begin
      checkValue($sformatf("pat_px%0d", i), 32'(p_rgb), 32'(bars[(i < 16) ? i / 2 : 8]));
      if (p_ready || !p_de) bad++;
      rawTick();
    end
    checkValue("pat_ready_low", 32'(bad), 32'd0);
    checkValue("pat_de_end", 32'(p_de), 32'd0);
    checkValue("pat_ufl_cnt", 32'(p_ufl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
